// File: rtl/if_id_queue_pkg.sv
// Shared CPU defines: pipeline exception record, IF/ID queue entry and queue defaults.
// Imported by the IF/ID instruction queue and by anything that produces or consumes its entries.
// Pure type/constant package; holds no logic.
package if_id_queue_pkg;

  // Exceptions detected so far for one instruction travelling down the pipe
  typedef struct packed {
    logic interrupt;
    logic fetch_addr_err;
    logic decode_err;
    logic overflow;
    logic syscall;
    logic brk;
    logic eret;
    logic wr_addr_err;
    logic rd_addr_err;
  } ExceptinPipeType;

  // One queued instruction as handed from IF to ID
  typedef struct packed {
    logic [31:0]     instr;
    logic [31:0]     pc;
    ExceptinPipeType except;
  } iq_entry_t;

  localparam int IQ_DEPTH   = 8;
  localparam int IQ_FETCH_W = 2;

endpackage

// File: rtl/if_id_queue.sv
// Purpose: circular instruction queue decoupling IF (up to FETCH_W per cycle) from ID (one per cycle).
// Latency: an entry pushed in cycle N is at the head in cycle N+1; head outputs are muxed from registers.
// Backpressure: IF_Ready drops when fewer than FETCH_W slots are free; offered groups are then ignored.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH   = IQ_DEPTH,
  parameter int FETCH_W = IQ_FETCH_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ID_Flush,
  input  logic                    ID_Wr,
  input  logic [FETCH_W-1:0]      IF_Valid,
  input  logic [32*FETCH_W-1:0]   IF_Instr,
  input  logic [32*FETCH_W-1:0]   IF_PC,
  input  ExceptinPipeType         IF_ExceptType [FETCH_W],
  output logic                    IF_Ready,
  output logic                    ID_Valid,
  output logic [31:0]             ID_Instr,
  output logic [31:0]             ID_PC,
  output logic [15:0]             ID_Imm16,
  output logic [4:0]              ID_rs,
  output logic [4:0]              ID_rt,
  output logic [4:0]              ID_rd,
  output ExceptinPipeType         ID_ExceptType,
  output logic [$clog2(DEPTH):0]  IQ_Count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - FETCH_W);

  iq_entry_t       mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count;
  logic [CW-1:0]   push_n;
  logic            pop;
  iq_entry_t       head_e;

  // Ready looks only at the registered count, so a same-cycle pop never opens room.
  assign IF_Ready = (count <= READY_MAX);
  assign ID_Valid = (count != '0);
  assign pop      = ID_Wr && ID_Valid;
  assign IQ_Count = count;
  assign head_e   = mem[head];

  // Number of slots accepted this cycle; valid bits are contiguous from slot 0, so a popcount suffices.
  always_comb begin
    push_n = '0;
    if (IF_Ready && !ID_Flush) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (IF_Valid[k]) push_n = push_n + CW'(1);
      end
    end
  end

  // Entry storage: write accepted slots in order from the tail; never cleared, the count decides validity.
  always_ff @(posedge clk) begin
    if (rst && !ID_Flush && IF_Ready) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (IF_Valid[k]) begin
          mem[tail + PW'(k)] <= '{instr:  IF_Instr[32*k +: 32],
                                  pc:     IF_PC[32*k +: 32],
                                  except: IF_ExceptType[k]};
        end
      end
    end
  end

  // Pointers and occupancy; reset beats flush, flush beats push and pop.
  always_ff @(posedge clk) begin
    if (!rst || ID_Flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      tail  <= tail + push_n[PW-1:0];
      if (pop) head <= head + PW'(1);
      count <= count + push_n - CW'(pop);
    end
  end

  // Head presentation: zeros when empty so ID decodes a NOP.
  always_comb begin
    ID_Instr      = '0;
    ID_PC         = '0;
    ID_ExceptType = '0;
    if (ID_Valid) begin
      ID_Instr      = head_e.instr;
      ID_PC         = head_e.pc;
      ID_ExceptType = head_e.except;
    end
  end

  // Decode fields are sliced from the stored word rather than kept as separate state.
  assign ID_Imm16 = ID_Instr[15:0];
  assign ID_rs    = ID_Instr[25:21];
  assign ID_rt    = ID_Instr[20:16];
  assign ID_rd    = ID_Instr[15:11];

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue with DEPTH=8, FETCH_W=2.
// Inputs change 1ns after the rising edge; outputs are checked at that same point.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            ID_Flush;
  logic            ID_Wr;
  logic [1:0]      IF_Valid;
  logic [63:0]     IF_Instr;
  logic [63:0]     IF_PC;
  ExceptinPipeType IF_ExceptType [2];
  logic            IF_Ready;
  logic            ID_Valid;
  logic [31:0]     ID_Instr;
  logic [31:0]     ID_PC;
  logic [15:0]     ID_Imm16;
  logic [4:0]      ID_rs;
  logic [4:0]      ID_rt;
  logic [4:0]      ID_rd;
  ExceptinPipeType ID_ExceptType;
  logic [3:0]      IQ_Count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_id_queue #(.DEPTH(8), .FETCH_W(2)) dut (
    .clk(clk), .rst(rst), .ID_Flush(ID_Flush), .ID_Wr(ID_Wr),
    .IF_Valid(IF_Valid), .IF_Instr(IF_Instr), .IF_PC(IF_PC),
    .IF_ExceptType(IF_ExceptType), .IF_Ready(IF_Ready), .ID_Valid(ID_Valid),
    .ID_Instr(ID_Instr), .ID_PC(ID_PC), .ID_Imm16(ID_Imm16),
    .ID_rs(ID_rs), .ID_rt(ID_rt), .ID_rd(ID_rd),
    .ID_ExceptType(ID_ExceptType), .IQ_Count(IQ_Count)
  );

  // IF must present valid slots contiguously from slot 0 whenever it can be heard
  always @(posedge clk) begin
    if (rst && IF_Ready)
      assert (IF_Valid != 2'b10) else $error("illegal IF_Valid pattern 2'b10");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input logic [1:0] v, input logic [31:0] i0, input logic [31:0] p0,
                            input logic [31:0] i1, input logic [31:0] p1);
    IF_Valid         = v;
    IF_Instr         = {i1, i0};
    IF_PC            = {p1, p0};
    IF_ExceptType[0] = '0;
    IF_ExceptType[1] = '0;
  endtask

  task automatic idle_inputs();
    drive_push(2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    ID_Wr    = 1'b0;
    ID_Flush = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
    checks++; if (IQ_Count !== 4'd0) begin errors++; $display("FAIL reset_count got=%0d want=0", IQ_Count); end
    checks++; if (IF_Ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b want=1", IF_Ready); end
    checks++; if (ID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", ID_Valid); end
    checks++; if (ID_Instr !== 32'h0) begin errors++; $display("FAIL reset_instr got=%h want=0", ID_Instr); end
    checks++; if (ID_PC !== 32'h0) begin errors++; $display("FAIL reset_pc got=%h want=0", ID_PC); end
  endtask

  task automatic test_first_push();
    do_reset();
    drive_push(2'b11, 32'h24020001, 32'hBFC00000, 32'h24030002, 32'hBFC00004);
    // no combinational IF-to-ID path
    checks++; if (ID_Valid !== 1'b0) begin errors++; $display("FAIL first_comb_path got=%b want=0", ID_Valid); end
    step();
    idle_inputs();
    checks++; if (ID_Valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b want=1", ID_Valid); end
    checks++; if (ID_PC !== 32'hBFC00000) begin errors++; $display("FAIL first_pc got=%h want=bfc00000", ID_PC); end
    checks++; if (ID_rt !== 5'd2) begin errors++; $display("FAIL first_rt got=%0d want=2", ID_rt); end
    checks++; if (ID_rs !== 5'd0) begin errors++; $display("FAIL first_rs got=%0d want=0", ID_rs); end
    checks++; if (ID_Imm16 !== 16'h0001) begin errors++; $display("FAIL first_imm got=%h want=0001", ID_Imm16); end
    checks++; if (IQ_Count !== 4'd2) begin errors++; $display("FAIL first_count got=%0d want=2", IQ_Count); end
    ID_Wr = 1'b1;
    step();
    checks++; if (ID_Instr !== 32'h24030002) begin errors++; $display("FAIL first_second_instr got=%h want=24030002", ID_Instr); end
    checks++; if (ID_rd !== 5'd0) begin errors++; $display("FAIL first_second_rd got=%0d want=0", ID_rd); end
    step();
    ID_Wr = 1'b0;
    checks++; if (IQ_Count !== 4'd0) begin errors++; $display("FAIL first_drain got=%0d want=0", IQ_Count); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive_push(2'b11, 32'h00001020, 32'h2000, 32'h00002020, 32'h2004);
    step();
    drive_push(2'b11, 32'h00003020, 32'h2008, 32'h00004020, 32'h200C);
    ID_Wr = 1'b1;
    step();
    idle_inputs();
    checks++; if (IQ_Count !== 4'd3) begin errors++; $display("FAIL b2b_count got=%0d want=3", IQ_Count); end
    checks++; if (ID_PC !== 32'h2004) begin errors++; $display("FAIL b2b_head got=%h want=2004", ID_PC); end
    checks++; if (ID_rd !== 5'd4) begin errors++; $display("FAIL b2b_rd got=%0d want=4", ID_rd); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int g = 0; g < 3; g++) begin
      drive_push(2'b11, 32'h24000000 | (32'h1000 + 8*g), 32'h1000 + 8*g,
                        32'h24000000 | (32'h1004 + 8*g), 32'h1004 + 8*g);
      step();
    end
    idle_inputs();
    checks++; if (IQ_Count !== 4'd6) begin errors++; $display("FAIL fill_count6 got=%0d want=6", IQ_Count); end
    checks++; if (IF_Ready !== 1'b1) begin errors++; $display("FAIL fill_ready6 got=%b want=1", IF_Ready); end
    drive_push(2'b11, 32'h24001018, 32'h1018, 32'h2400101C, 32'h101C);
    step();
    checks++; if (IQ_Count !== 4'd8) begin errors++; $display("FAIL fill_count8 got=%0d want=8", IQ_Count); end
    checks++; if (IF_Ready !== 1'b0) begin errors++; $display("FAIL fill_ready8 got=%b want=0", IF_Ready); end
    drive_push(2'b11, 32'h24001020, 32'h1020, 32'h24001024, 32'h1024);
    step();
    checks++; if (IQ_Count !== 4'd8) begin errors++; $display("FAIL fill_fifth_count got=%0d want=8", IQ_Count); end
    checks++; if (ID_PC !== 32'h1000) begin errors++; $display("FAIL fill_fifth_head got=%h want=1000", ID_PC); end
  endtask

  // Continues from a full queue holding PCs 0x1000..0x101C
  task automatic test_wrap();
    int mc = 8;
    logic [31:0] exp_pop = 32'h1000;
    logic [31:0] next_pc = 32'h1020;
    bit acc;
    for (int i = 0; i < 12; i++) begin
      checks++; if (IQ_Count !== 4'(mc)) begin errors++; $display("FAIL wrap_count[%0d] got=%0d want=%0d", i, IQ_Count, mc); end
      checks++; if (IF_Ready !== (mc <= 6)) begin errors++; $display("FAIL wrap_ready[%0d] got=%b want=%b", i, IF_Ready, (mc <= 6)); end
      checks++; if (ID_PC !== exp_pop) begin errors++; $display("FAIL wrap_pc[%0d] got=%h want=%h", i, ID_PC, exp_pop); end
      acc = (mc <= 6);
      drive_push(2'b01, 32'h24000000 | next_pc, next_pc, 32'hFFFFFFFF, 32'hDEAD0000);
      ID_Wr = 1'b1;
      step();
      exp_pop = exp_pop + 32'd4;
      if (acc) next_pc = next_pc + 32'd4;
      mc = mc + int'(acc) - 1;
    end
    idle_inputs();
    checks++; if (ID_Instr !== (32'h24000000 | exp_pop)) begin errors++; $display("FAIL wrap_final_instr got=%h want=%h", ID_Instr, 32'h24000000 | exp_pop); end
  endtask

  task automatic test_flush();
    do_reset();
    drive_push(2'b11, 32'h1, 32'h3000, 32'h2, 32'h3004);
    step();
    drive_push(2'b11, 32'h3, 32'h3008, 32'h4, 32'h300C);
    step();
    drive_push(2'b01, 32'h5, 32'h3010, 32'h0, 32'h0);
    step();
    idle_inputs();
    checks++; if (IQ_Count !== 4'd5) begin errors++; $display("FAIL flush_pre_count got=%0d want=5", IQ_Count); end
    drive_push(2'b11, 32'h6, 32'h3014, 32'h7, 32'h3018);
    ID_Wr    = 1'b1;
    ID_Flush = 1'b1;
    step();
    idle_inputs();
    checks++; if (IQ_Count !== 4'd0) begin errors++; $display("FAIL flush_count got=%0d want=0", IQ_Count); end
    checks++; if (ID_Valid !== 1'b0) begin errors++; $display("FAIL flush_valid got=%b want=0", ID_Valid); end
    checks++; if (ID_Instr !== 32'h0) begin errors++; $display("FAIL flush_instr got=%h want=0", ID_Instr); end
    checks++; if (ID_PC !== 32'h0) begin errors++; $display("FAIL flush_pc got=%h want=0", ID_PC); end
    drive_push(2'b01, 32'h8, 32'h4000, 32'h0, 32'h0);
    step();
    idle_inputs();
    checks++; if (IQ_Count !== 4'd1) begin errors++; $display("FAIL flush_refill_count got=%0d want=1", IQ_Count); end
    checks++; if (ID_PC !== 32'h4000) begin errors++; $display("FAIL flush_refill_pc got=%h want=4000", ID_PC); end
  endtask

  task automatic test_except();
    ExceptinPipeType rec;
    rec = '0;
    rec.interrupt      = 1'b1;
    rec.fetch_addr_err = 1'b1;
    rec.rd_addr_err    = 1'b1;
    do_reset();
    ID_Wr = 1'b1;
    step();
    ID_Wr = 1'b0;
    checks++; if (IQ_Count !== 4'd0) begin errors++; $display("FAIL exc_empty_pop got=%0d want=0", IQ_Count); end
    drive_push(2'b01, 32'h00000000, 32'h00000003, 32'h0, 32'h0);
    IF_ExceptType[0] = rec;
    step();
    idle_inputs();
    checks++; if (ID_ExceptType !== rec) begin errors++; $display("FAIL exc_record got=%h want=%h", ID_ExceptType, rec); end
    checks++; if (ID_PC !== 32'h3) begin errors++; $display("FAIL exc_pc got=%h want=3", ID_PC); end
    ID_Wr = 1'b1;
    step();
    checks++; if (IQ_Count !== 4'd0) begin errors++; $display("FAIL exc_after_pop got=%0d want=0", IQ_Count); end
    checks++; if (ID_ExceptType !== '0) begin errors++; $display("FAIL exc_zero_when_empty got=%h want=0", ID_ExceptType); end
    step();
    ID_Wr = 1'b0;
    checks++; if (IQ_Count !== 4'd0) begin errors++; $display("FAIL exc_second_empty_pop got=%0d want=0", IQ_Count); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    drive_push(2'b11, 32'h24E7FFFF, 32'h5000, 32'h24E7FFFF, 32'h5004);
    step();
    step();
    checks++; if (IQ_Count !== 4'd4) begin errors++; $display("FAIL mrst_pre_count got=%0d want=4", IQ_Count); end
    rst   = 1'b0;
    ID_Wr = 1'b1;
    step();
    rst = 1'b1;
    idle_inputs();
    checks++; if (IQ_Count !== 4'd0) begin errors++; $display("FAIL mrst_count got=%0d want=0", IQ_Count); end
    checks++; if (IF_Ready !== 1'b1) begin errors++; $display("FAIL mrst_ready got=%b want=1", IF_Ready); end
    checks++; if (ID_Valid !== 1'b0) begin errors++; $display("FAIL mrst_valid got=%b want=0", ID_Valid); end
    checks++; if ({ID_Instr, ID_PC} !== 64'h0) begin errors++; $display("FAIL mrst_instr_pc got=%h want=0", {ID_Instr, ID_PC}); end
    checks++; if ({ID_Imm16, ID_rs, ID_rt, ID_rd} !== 31'h0) begin errors++; $display("FAIL mrst_fields got=%h want=0", {ID_Imm16, ID_rs, ID_rt, ID_rd}); end
    checks++; if (ID_ExceptType !== '0) begin errors++; $display("FAIL mrst_except got=%h want=0", ID_ExceptType); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_first_push();
    test_back_to_back();
    test_fill();
    test_wrap();
    test_flush();
    test_except();
    test_mid_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
